// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap core: state encoding and cascade limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1,
    StLap   = 2'd2,
    StStop  = 2'd3
  } sw_state_e;

  // Terminal values of the centisecond/second/minute digits before they wrap to 0.
  localparam logic [6:0] CS_MAX  = 7'd99;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/sw_tick_gen.sv
// Centisecond prescaler: counts clk cycles while enabled and fires a tick on the last one.
module sw_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  // Tick only while enabled, so a held (stopped) count does not keep firing.
  assign tick = en && (r_cnt == CntLast);

  // Prescaler: cleared on request, free-running while enabled, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CntLast) ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch controller with run/stop/clear/lap FSM, time cascade, lap snapshot and lap counter.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned HOUR_MAX  = 24,
  parameter int unsigned LAP_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_runstop,
  input  logic                 i_clear,
  input  logic                 i_lap,
  output logic [6:0]           o_cs,
  output logic [5:0]           o_sec,
  output logic [5:0]           o_min,
  output logic [4:0]           o_hour,
  output logic [LAP_CNT_W-1:0] o_lap_cnt,
  output logic                 o_running,
  output logic                 o_lap_active,
  output logic                 o_wrap
);

  localparam logic [4:0] HourLast = 5'(HOUR_MAX - 1);

  sw_state_e r_state;
  sw_state_e w_state_next;

  logic [6:0] r_cs;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic [6:0] r_snap_cs;
  logic [5:0] r_snap_sec;
  logic [5:0] r_snap_min;
  logic [4:0] r_snap_hour;
  logic [LAP_CNT_W-1:0] r_lap_cnt;
  logic r_wrap;

  logic w_tick;
  logic w_en;
  logic w_clr;
  logic w_take_lap;
  logic w_cs_last;
  logic w_sec_last;
  logic w_min_last;
  logic w_hour_last;

  // Counting runs in RUN and LAP; CLEAR holds zero, and STOP+clear zeroes on the way to CLEAR.
  assign w_en       = (r_state == StRun) || (r_state == StLap);
  assign w_clr      = (r_state == StClear) || ((r_state == StStop) && i_clear);
  // runstop outranks lap, so a coincident pair stops without snapshotting.
  assign w_take_lap = (r_state == StRun) && !i_runstop && i_lap;

  assign w_cs_last   = (r_cs == CS_MAX);
  assign w_sec_last  = (r_sec == SEC_MAX);
  assign w_min_last  = (r_min == MIN_MAX);
  assign w_hour_last = (r_hour == HourLast);

  sw_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .clr (w_clr),
    .tick(w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StClear;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; priority clear > runstop > lap, ignored pulses leave the state alone.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StClear: if (i_runstop) w_state_next = StRun;
      StRun: begin
        if (i_runstop)  w_state_next = StStop;
        else if (i_lap) w_state_next = StLap;
      end
      StLap: begin
        if (i_runstop)  w_state_next = StStop;
        else if (i_lap) w_state_next = StRun;
      end
      StStop: begin
        if (i_clear)        w_state_next = StClear;
        else if (i_runstop) w_state_next = StRun;
      end
      default: w_state_next = StClear;
    endcase
  end

  // Output decode and display mux: LAP shows the frozen snapshot, all other states show live time.
  always_comb begin
    o_running    = w_en;
    o_lap_active = (r_state == StLap);
    o_cs         = r_cs;
    o_sec        = r_sec;
    o_min        = r_min;
    o_hour       = r_hour;
    if (r_state == StLap) begin
      o_cs   = r_snap_cs;
      o_sec  = r_snap_sec;
      o_min  = r_snap_min;
      o_hour = r_snap_hour;
    end
  end

  // Live time cascade; all carries resolve within the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs   <= '0;
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_wrap <= 1'b0;
    end else if (w_clr) begin
      r_cs   <= '0;
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick && w_cs_last && w_sec_last && w_min_last && w_hour_last;
      if (w_tick) begin
        r_cs <= w_cs_last ? '0 : r_cs + 7'd1;
        if (w_cs_last) begin
          r_sec <= w_sec_last ? '0 : r_sec + 6'd1;
          if (w_sec_last) begin
            r_min <= w_min_last ? '0 : r_min + 6'd1;
            if (w_min_last) begin
              r_hour <= w_hour_last ? '0 : r_hour + 5'd1;
            end
          end
        end
      end
    end
  end

  // Snapshot captures the pre-increment live time on entry to LAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_cs   <= '0;
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hour <= '0;
    end else if (w_take_lap) begin
      r_snap_cs   <= r_cs;
      r_snap_sec  <= r_sec;
      r_snap_min  <= r_min;
      r_snap_hour <= r_hour;
    end
  end

  // Saturating lap counter, zeroed together with the time on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_cnt <= '0;
    end else if (w_clr) begin
      r_lap_cnt <= '0;
    end else if (w_take_lap && (r_lap_cnt != '1)) begin
      r_lap_cnt <= r_lap_cnt + LAP_CNT_W'(1);
    end
  end

  assign o_lap_cnt = r_lap_cnt;
  assign o_wrap    = r_wrap;

endmodule
